char_ram_arbiter: RTL and testbench

CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

---
 rtl/char_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_char_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_ram_arbiter.sv
// Character RAM arbiter: one RAM slot per cycle shared by VGA fetches, a CPU read
// FSM and a small CPU write queue (priority VGA > read > queued write).
module char_ram_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_re,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_rbusy,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              err_ovf
);
    localparam int PTR_W   = $clog2(WFIFO_DEPTH);
    localparam int VGA_LAT = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ISSUE, R_DATA} rd_state_t;

    wr_entry_t        fifo_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty;
    logic             push_req, rd_grant, wr_slot, pop, bypass, store;
    wr_entry_t        head;

    rd_state_t         rd_state, rd_next;
    logic [ADDR_W-1:0] rd_addr;

    logic [VGA_LAT:1]  vld_pipe;

    assign full      = (count == (PTR_W+1)'(WFIFO_DEPTH));
    assign empty     = (count == '0);
    assign cpu_ready = ~full;
    assign push_req  = cpu_we & ~full;

    // The read takes the slot one cycle before R_ISSUE so its address sits on
    // ram_addr during R_ISSUE and ram_dout is valid in R_DATA.
    assign rd_grant  = (rd_state == R_WAIT) & empty & ~vga_req;
    assign wr_slot   = ~vga_req & (rd_state != R_ISSUE) & ~rd_grant;
    assign pop       = wr_slot & ~empty;
    // An empty queue with a free slot writes straight through without storing.
    assign bypass    = wr_slot & empty & push_req;
    assign store     = push_req & ~bypass;
    assign head      = empty ? wr_entry_t'{addr: cpu_addr, data: cpu_wdata} : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (store) fifo_mem[wr_ptr] <= wr_entry_t'{addr: cpu_addr, data: cpu_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cpu_we && full) err_ovf <= 1'b1;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (cpu_re) rd_next = R_WAIT;
            R_WAIT:  if (rd_grant) rd_next = R_ISSUE;
            R_ISSUE: rd_next = R_DATA;
            R_DATA:  rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state   <= R_IDLE;
            rd_addr    <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            rd_state   <= rd_next;
            cpu_rvalid <= (rd_state == R_DATA);
            if (rd_state == R_IDLE && cpu_re) rd_addr <= cpu_addr;
            if (rd_state == R_DATA) cpu_rdata <= ram_dout;
        end
    end

    assign cpu_rbusy = (rd_state != R_IDLE) | cpu_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else if (vga_req) begin
            ram_addr <= vga_addr;
            ram_we   <= 1'b0;
        end else if (rd_grant) begin
            ram_addr <= rd_addr;
            ram_we   <= 1'b0;
        end else if (pop || bypass) begin
            ram_addr <= head.addr;
            ram_din  <= head.data;
            ram_we   <= 1'b1;
        end else begin
            ram_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[VGA_LAT-1:1], vga_req};
    end

    assign vga_valid = vld_pipe[VGA_LAT];
    assign vga_data  = ram_dout;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter with a synchronous RAM model and
// scoreboards for RAM writes and VGA fetch data.
module tb_char_ram_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_we = 1'b0, cpu_re = 1'b0, vga_req = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0, vga_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ready, cpu_rvalid, cpu_rbusy, vga_valid, ram_we, err_ovf;
    logic [DATA_W-1:0] cpu_rdata, vga_data, ram_din, ram_dout;
    logic [ADDR_W-1:0] ram_addr;

    char_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_rbusy(cpu_rbusy),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int total = 0, bad = 0;
    int wr_cnt = 0, vv_cnt = 0, rv_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] wq [$];
    logic [DATA_W-1:0]        vq [$];
    logic [ADDR_W+DATA_W-1:0] we_exp;
    logic [DATA_W-1:0]        vd_exp;

    function automatic logic [DATA_W-1:0] init_val(int a);
        return DATA_W'(a * 3 + 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_have(input string tag, input int have);
        total++;
        assert (have != 0) else begin
            bad++;
            $error("FAIL %s: observed=unexpected event expected=no event", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vga_drive(input logic on, input int a);
        vga_req  = on;
        vga_addr = ADDR_W'(a);
        if (on) vq.push_back(init_val(a));
    endtask

    always @(negedge clk) begin
        if (ram_we) begin
            wr_cnt++;
            chk_have("wr_unexpected", wq.size());
            if (wq.size() != 0) begin
                we_exp = wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(we_exp[ADDR_W+DATA_W-1:DATA_W]));
                chk("wr_data", 32'(ram_din), 32'(we_exp[DATA_W-1:0]));
            end
        end
        if (vga_valid) begin
            vv_cnt++;
            chk_have("vga_unexpected", vq.size());
            if (vq.size() != 0) begin
                vd_exp = vq.pop_front();
                chk("vga_data", 32'(vga_data), 32'(vd_exp));
            end
        end
        if (cpu_rvalid) rv_cnt++;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},  32'(cpu_ready), 1);
        chk({tag, "_rbusy"},  32'(cpu_rbusy), 0);
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 0);
        chk({tag, "_rdata"},  32'(cpu_rdata), 0);
        chk({tag, "_vvalid"}, 32'(vga_valid), 0);
        chk({tag, "_we"},     32'(ram_we), 0);
        chk({tag, "_raddr"},  32'(ram_addr), 0);
        chk({tag, "_rdin"},   32'(ram_din), 0);
        chk({tag, "_ovf"},    32'(err_ovf), 0);
    endtask

    task automatic wait_rvalid(input string tag, input logic [DATA_W-1:0] exp);
        int seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            if (cpu_rvalid) seen = 1;
            else tick();
        end
        chk({tag, "_rvalid_seen"}, 32'(seen), 1);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp));
    endtask

    int base_w, base_v, base_r;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_val(i);
        rst = 1'b0;
        #2;
        chk_reset("rst0");
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Single write on an idle bus lands one cycle after the strobe
        cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 16'h1F41;
        wq.push_back({13'h0005, 16'h1F41});
        tick();
        cpu_we = 1'b0;
        chk("w1_we", 32'(ram_we), 1);
        chk("w1_addr", 32'(ram_addr), 32'h0005);
        chk("w1_din", 32'(ram_din), 32'h1F41);
        tick();
        chk("w1_we_off", 32'(ram_we), 0);

        // VGA holds the bus for 10 cycles while 3 writes queue behind it
        base_w = wr_cnt; base_v = vv_cnt;
        for (int i = 0; i < 10; i++) begin
            vga_drive(1'b1, 'h1000 + i);
            cpu_we = (i < 3);
            cpu_addr = ADDR_W'('h20 + i); cpu_wdata = DATA_W'('hA000 + i);
            if (i < 3) wq.push_back({ADDR_W'('h20 + i), DATA_W'('hA000 + i)});
            tick();
        end
        cpu_we = 1'b0;
        vga_drive(1'b0, 0);
        tick();
        chk("vga_block_wr", 32'(wr_cnt - base_w), 0);
        repeat (3) tick();
        chk("vga_drain_wr", 32'(wr_cnt - base_w), 3);
        chk("vga_cnt", 32'(vv_cnt - base_v), 10);

        // Overflow: five writes into a depth-4 queue blocked by VGA
        base_w = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            vga_drive(1'b1, 'h1100 + i);
            cpu_we = 1'b1; cpu_addr = ADDR_W'('h40 + i); cpu_wdata = DATA_W'('hB000 + i);
            if (i < 4) wq.push_back({ADDR_W'('h40 + i), DATA_W'('hB000 + i)});
            tick();
            if (i == 2) chk("ovf_ready_3", 32'(cpu_ready), 1);
            if (i == 2) chk("ovf_flag_3", 32'(err_ovf), 0);
            if (i == 3) chk("ovf_ready_4", 32'(cpu_ready), 0);
        end
        cpu_we = 1'b0;
        chk("ovf_flag", 32'(err_ovf), 1);
        vga_drive(1'b1, 'h1105);
        tick();
        vga_drive(1'b0, 0);
        repeat (8) tick();
        chk("ovf_wr_cnt", 32'(wr_cnt - base_w), 4);
        chk("ovf_ready_back", 32'(cpu_ready), 1);

        // Read-after-write ordering
        base_r = rv_cnt;
        cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 16'h00AA;
        wq.push_back({13'h0010, 16'h00AA});
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b1; cpu_addr = 13'h0010;
        tick();
        cpu_re = 1'b0;
        chk("raw_rbusy", 32'(cpu_rbusy), 1);
        wait_rvalid("raw", 16'h00AA);
        repeat (3) tick();
        chk("raw_rv_once", 32'(rv_cnt - base_r), 1);
        chk("raw_rbusy_off", 32'(cpu_rbusy), 0);

        // Read stalled by VGA, then served from preloaded contents
        base_r = rv_cnt;
        cpu_re = 1'b1; cpu_addr = 13'h1005;
        vga_drive(1'b1, 'h1200);
        tick();
        cpu_re = 1'b0;
        for (int i = 1; i < 4; i++) begin
            vga_drive(1'b1, 'h1200 + i);
            tick();
        end
        chk("rvga_wait", 32'(cpu_rbusy), 1);
        chk("rvga_no_rv", 32'(rv_cnt - base_r), 0);
        vga_drive(1'b0, 0);
        wait_rvalid("rvga", init_val('h1005));
        repeat (3) tick();

        // Reset with two queued writes and a read parked in R_WAIT
        for (int i = 0; i < 2; i++) begin
            vga_drive(1'b1, 'h1300 + i);
            cpu_we = 1'b1; cpu_addr = ADDR_W'('h60 + i); cpu_wdata = DATA_W'('hC000 + i);
            tick();
        end
        cpu_we = 1'b0;
        cpu_re = 1'b1; cpu_addr = 13'h0060;
        vga_drive(1'b1, 'h1302);
        tick();
        cpu_re = 1'b0;
        vga_drive(1'b1, 'h1303);
        tick();
        chk("mrst_pre_rbusy", 32'(cpu_rbusy), 1);
        rst = 1'b0;
        vga_drive(1'b0, 0);
        #1;
        vq.delete();
        chk_reset("mrst");
        repeat (2) tick();
        rst = 1'b1;
        base_w = wr_cnt; base_r = rv_cnt; base_v = vv_cnt;
        repeat (10) tick();
        chk("post_rst_wr", 32'(wr_cnt - base_w), 0);
        chk("post_rst_rv", 32'(rv_cnt - base_r), 0);
        chk("post_rst_vv", 32'(vv_cnt - base_v), 0);
        chk("post_rst_rbusy", 32'(cpu_rbusy), 0);
        chk("wq_empty", 32'(wq.size()), 0);
        chk("vq_empty", 32'(vq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
